// File: rtl/ps2_receive_pkg.sv
// Purpose: shared constants for the PS/2 receiver: FSM state encoding,
//          frame geometry, common scan codes and the parity helper.
// Ports:   none (package).
package ps2_receive_pkg;

  typedef logic [1:0] ps2_state_t;

  localparam ps2_state_t ST_IDLE   = 2'd0;
  localparam ps2_state_t ST_DATA   = 2'd1;
  localparam ps2_state_t ST_PARITY = 2'd2;
  localparam ps2_state_t ST_STOP   = 2'd3;

  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_12 = 8'h12;
  localparam logic [7:0] SC_59 = 8'h59;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_receive_if.sv
// Purpose: output bundle of the PS/2 receiver towards the UART transmitter.
// Signals: rx_byte    last good scan code (held between frames)
//          valid      one-cycle pulse, rx_byte is new
//          parity_err one-cycle pulse, frame dropped on parity
//          frame_err  one-cycle pulse, bad stop bit or mid-frame stall
//          busy       frame in progress
// Modports: master = receiver side (drives), slave = consumer side.
interface ps2_receive_if;
  logic [7:0] rx_byte;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (output rx_byte, valid, parity_err, frame_err, busy);
  modport slave  (input  rx_byte, valid, parity_err, frame_err, busy);
endinterface

// File: rtl/ps2_receive_input_filter.sv
// Purpose: brings the asynchronous PS/2 lines into clk_i, debounces the
//          PS/2 clock and produces a one-cycle strobe on its falling edge.
// Ports:   clk_i, rst_i     system clock, synchronous active-high reset
//          ps2_clk_i        raw PS/2 clock line
//          ps2_data_i       raw PS/2 data line
//          data_sync_o      synchronised data line
//          fall_o           one-cycle strobe, filtered clock went 1->0
module ps2_receive_input_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic data_sync_o,
  output logic fall_o
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;
  logic          filt_prev_q;

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk_i};
    data_sync_d = {data_sync_q[0], ps2_data_i};
    cnt_d       = '0;
    filt_d      = filt_q;
    // Count consecutive samples disagreeing with the filtered level; any
    // agreeing sample restarts the count, so short glitches never get through.
    if (clk_sync_q[1] != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = clk_sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      cnt_q       <= '0;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      cnt_q       <= cnt_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
    end
  end

  assign data_sync_o = data_sync_q[1];
  assign fall_o      = filt_prev_q & ~filt_q;

endmodule

// File: rtl/ps2_receive.sv
// Purpose: PS/2 keyboard frame receiver (start, 8 data LSB first, odd
//          parity, stop). Emits good scan codes and error pulses.
// Ports:   clk_i       system clock
//          rst_i       synchronous active-high reset
//          ps2_clk_i   raw PS/2 clock line (idle high)
//          ps2_data_i  raw PS/2 data line (idle high)
//          rx_o        output bundle (byte, valid, parity_err, frame_err, busy)
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | waiting for a start bit (data low on clock fall)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | next fall carries the parity bit
// ST_STOP   | next fall carries the stop bit, frame is judged
module ps2_receive
  import ps2_receive_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ps2_clk_i,
  input  logic          ps2_data_i,
  ps2_receive_if.master rx_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic          data_s;
  logic          fall_s;
  logic          timeout;
  ps2_state_t    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;

  ps2_receive_input_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .data_sync_o (data_s),
    .fall_o      (fall_s)
  );

  // A fall arriving on the terminal cycle still counts as progress.
  assign timeout = (state_q != ST_IDLE) && !fall_s && (tmo_q == TMO_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tmo_q     <= tmo_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    unique case (state_q)
      ST_IDLE: begin
        // A fall with data high is a glitch, not a start bit.
        if (fall_s && !data_s) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (fall_s) begin
          shift_d[bit_cnt_q] = data_s;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (fall_s) begin
          parity_d = data_s;
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout) begin
      state_d = ST_IDLE;
    end

    if ((state_q == ST_IDLE) || fall_s || timeout) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_comb begin
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    byte_d  = byte_q;
    if (timeout) begin
      ferr_d = 1'b1;
    end else if ((state_q == ST_STOP) && fall_s) begin
      // A low stop bit outranks a parity error.
      if (!data_s) begin
        ferr_d = 1'b1;
      end else if (odd_parity_ok(shift_q, parity_q)) begin
        valid_d = 1'b1;
        byte_d  = shift_q;
      end else begin
        perr_d = 1'b1;
      end
    end
  end

  assign rx_o.rx_byte    = byte_q;
  assign rx_o.valid      = valid_q;
  assign rx_o.parity_err = perr_q;
  assign rx_o.frame_err  = ferr_q;
  assign rx_o.busy       = (state_q != ST_IDLE);

endmodule
